// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate / load-data extension unit with a 2-entry output FIFO.
// Results are computed on acceptance and are visible one cycle later.
// Optional feature macro: EXT_BYTE_HALF_EN enables the byte/half load modes (4-7).
// Without it, those modes return the zero-extended immediate with out_err set,
// and the in_data/in_boff datapath is left out of the build.
module imm_ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [OUT_W-1:0] in_data,
  input  logic [1:0]       in_boff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic             push, pop;
  logic [OUT_W-1:0] new_data;
  logic             new_err;

  // Immediate modes 0-3; anything else yields the zero-extended immediate.
  function automatic logic [OUT_W-1:0] ext_imm(input logic [2:0] mode,
                                               input logic [IMM_W-1:0] imm);
    logic signed [OUT_W-1:0] sx;
    logic        [OUT_W-1:0] r;
    sx = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (mode)
      3'd1:    r = sx;
      3'd2:    r = {imm, {(OUT_W-IMM_W){1'b0}}};
      3'd3:    r = sx <<< 2;
      default: r = {{(OUT_W-IMM_W){1'b0}}, imm};
    endcase
    return r;
  endfunction

`ifdef EXT_BYTE_HALF_EN
  // Byte/half load extraction: lmode 0 LB, 1 LBU, 2 LH, 3 LHU.
  function automatic logic [OUT_W-1:0] ext_load(input logic [1:0]       lmode,
                                                input logic [OUT_W-1:0] data,
                                                input logic [1:0]       boff);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [OUT_W-1:0] r;
    case (boff)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = boff[1] ? data[31:16] : data[15:0];
    case (lmode)
      2'd0:    r = {{(OUT_W-8){b[7]}}, b};
      2'd1:    r = {{(OUT_W-8){1'b0}}, b};
      2'd2:    r = {{(OUT_W-16){h[15]}}, h};
      default: r = {{(OUT_W-16){1'b0}}, h};
    endcase
    return r;
  endfunction
`else
  // Load-word inputs have no consumer in this build.
  logic unused_byte_half;
  assign unused_byte_half = ^{in_data, in_boff};
`endif

  // Handshake decode from registered state only; in_ready never sees out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = data0_q;
  assign out_err   = err0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Result of the request currently on the input side.
  always_comb begin
    new_data = '0;
    new_err  = 1'b0;
`ifdef EXT_BYTE_HALF_EN
    if (in_mode[2]) new_data = ext_load(in_mode[1:0], in_data, in_boff);
    else            new_data = ext_imm(in_mode, in_imm);
`else
    new_data = ext_imm(in_mode, in_imm);
    new_err  = in_mode[2];
`endif
  end

  // Occupancy FSM and FIFO entry movement; flush overrides any push or pop.
  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    err0_d  = err0_q;
    data1_d = data1_q;
    err1_d  = err1_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            data0_d = new_data;
            err0_d  = new_err;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push) begin
            if (pop) begin
              data0_d = new_data;
              err0_d  = new_err;
            end else begin
              data1_d = new_data;
              err1_d  = new_err;
              state_d = FULL;
            end
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            data0_d = data1_q;
            err0_d  = err1_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and buffer registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      data0_q <= '0;
      err0_q  <= 1'b0;
      data1_q <= '0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data0_q <= data0_d;
      err0_q  <= err0_d;
      data1_q <= data1_d;
      err1_q  <= err1_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: directed vectors plus random traffic against
// a queue-based reference model.
module tb_imm_ext_pipe;

  localparam int IMM_W = 16;
  localparam int OUT_W = 32;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_mode;
  logic [IMM_W-1:0] in_imm;
  logic [OUT_W-1:0] in_data;
  logic [1:0]       in_boff;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [32:0] q[$];

  imm_ext_pipe #(.IMM_W(IMM_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_imm(in_imm), .in_data(in_data), .in_boff(in_boff),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {err, data} computed from the mode rules with integers.
  function automatic logic [32:0] ref_ext(input logic [2:0] mode, input logic [15:0] imm,
                                          input logic [31:0] data, input logic [1:0] boff);
    longint iv, sv, v, b, h;
    bit err;
    err = 1'b0;
    iv  = longint'({48'b0, imm});
    sv  = (iv >= 32768) ? iv - 65536 : iv;
    b   = (longint'({32'b0, data}) >> (8 * int'(boff))) & 255;
    h   = (longint'({32'b0, data}) >> (16 * (int'(boff) / 2))) & 65535;
    case (mode)
      3'd0: v = iv;
      3'd1: v = sv;
      3'd2: v = iv * 65536;
      3'd3: v = sv * 4;
      default: begin
`ifdef EXT_BYTE_HALF_EN
        if (mode == 3'd4)      v = (b >= 128) ? b - 256 : b;
        else if (mode == 3'd5) v = b;
        else if (mode == 3'd6) v = (h >= 32768) ? h - 65536 : h;
        else                   v = h;
`else
        v   = iv;
        err = 1'b1;
`endif
      end
    endcase
    return {err, v[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][31:0]);
      chk("out_err", 32'(out_err), 32'(q[0][32]));
    end
  endtask

  // One clock: predict handshakes, advance the model at the edge, check after it.
  task automatic step();
    bit push, pop;
    logic [32:0] nv;
    push = in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && out_ready;
    nv   = ref_ext(in_mode, in_imm, in_data, in_boff);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(nv);
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [2:0] mode, input logic [15:0] imm,
                       input logic [31:0] data, input logic [1:0] boff);
    in_valid = v;
    in_mode  = mode;
    in_imm   = imm;
    in_data  = data;
    in_boff  = boff;
  endtask

  initial begin
    logic [31:0] basic_exp [4];
    basic_exp[0] = 32'h00008001;
    basic_exp[1] = 32'hFFFF8001;
    basic_exp[2] = 32'h80010000;
    basic_exp[3] = 32'hFFFE0004;

    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    #5 reset = 1'b1;

    // Immediate modes with a free-running consumer.
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 3'(m), 16'h8001, 32'h0, 2'd0);
      step();
      chk("basic_mode", out_data, basic_exp[m]);
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    step();

`ifdef EXT_BYTE_HALF_EN
    drive(1'b1, 3'd4, 16'h1234, 32'h80FF7F01, 2'd2); step(); chk("lb", out_data, 32'hFFFFFFFF);
    drive(1'b1, 3'd5, 16'h1234, 32'h80FF7F01, 2'd3); step(); chk("lbu", out_data, 32'h00000080);
    drive(1'b1, 3'd6, 16'h1234, 32'h80FF7F01, 2'd2); step(); chk("lh", out_data, 32'hFFFF80FF);
    drive(1'b1, 3'd7, 16'h1234, 32'h80FF7F01, 2'd0); step(); chk("lhu", out_data, 32'h00007F01);
    chk("lhu_err", 32'(out_err), 32'd0);
`else
    drive(1'b1, 3'd4, 16'h00F0, 32'hDEADBEEF, 2'd1); step();
    chk("off_m4_data", out_data, 32'h000000F0);
    chk("off_m4_err", 32'(out_err), 32'd1);
    drive(1'b1, 3'd1, 16'h0005, 32'h0, 2'd0); step();
    chk("off_m1_err", 32'(out_err), 32'd0);
    chk("off_m1_data", out_data, 32'h00000005);
`endif
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    step();

    // Backpressure: A, B fill the buffer, C waits until space opens.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h00AA, 32'h0, 2'd0); step(); chk("bp_a", out_data, 32'h000000AA);
    drive(1'b1, 3'd1, 16'h00BB, 32'h0, 2'd0); step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", out_data, 32'h000000AA);
    drive(1'b1, 3'd2, 16'h00CC, 32'h0, 2'd0); step(); chk("bp_hold_a2", out_data, 32'h000000AA);
    out_ready = 1'b1;
    step(); chk("bp_b", out_data, 32'h000000BB);
    step(); chk("bp_c", out_data, 32'h00CC0000);
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    step(); chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush while full, with a same-cycle request and pop.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0011, 32'h0, 2'd0); step();
    drive(1'b1, 3'd0, 16'h0022, 32'h0, 2'd0); step();
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 3'd0, 16'h0033, 32'h0, 2'd0); step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0); step();
    chk("flush_absent", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges while one entry is held.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h1234, 32'h0, 2'd0); step();
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    q.delete();
    #1 reset = 1'b1;
    drive(1'b1, 3'd1, 16'h4321, 32'h0, 2'd0); step();
    chk("arst_first", out_data, 32'h00004321);
    drive(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    out_ready = 1'b1;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom()),
            32'($urandom()), 2'($urandom_range(0, 3)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
